// File: rtl/cp0_exception_unit.sv
// CP0 exception unit: holds BadVAddr/Count/Compare/Status/Cause/EPC at the
// MEM/WB boundary, folds MEM-stage exception flags and pending interrupts into
// a single exception code, and applies exception entry / ERET / MTC0 updates.
//
// Interface note: mem_valid_i qualifies every mem_* input for the current
// cycle only; there is no backpressure. When mem_valid_i is low the mem_*
// inputs are ignored and no exception is reported or taken.
module cp0_exception_unit #(
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000,
  parameter int          TIMER_IP_BIT = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [7:0]  mem_excflags_i,
  input  logic        mem_is_store_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] mem_bad_addr_i,
  input  logic [5:0]  int_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  output logic [31:0] exception_type_o,
  output logic [31:0] cp0_epc_o,
  output logic        timer_int_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'ha;
  localparam logic [31:0] EXC_OV   = 32'hc;
  localparam logic [31:0] EXC_TR   = 32'hd;
  localparam logic [31:0] EXC_ERET = 32'he;

  // Position of the timer within the hardware IP[7:2] field.
  localparam int          TIMER_IDX  = TIMER_IP_BIT - 2;
  localparam logic [5:0]  TIMER_MASK = 6'(1) << TIMER_IDX;

  // Status fields
  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  // Cause fields
  localparam int CA_BD  = 31;

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q,    count_d;
  logic [31:0] compare_q,  compare_d;
  logic [31:0] status_q,   status_d;
  logic [31:0] cause_q,    cause_d;
  logic [31:0] epc_q,      epc_d;
  logic        timer_int_q, timer_int_d;

  logic [31:0] status_f, cause_f, epc_f;
  logic        int_pending;
  logic [31:0] exc_type;
  logic        take_exc, is_eret, wr_ok;
  logic [5:0]  ip_hw;

  // Forwarded views: an MTC0 in flight this cycle is visible to readers now.
  always_comb begin
    status_f = status_q;
    cause_f  = cause_q;
    epc_f    = epc_q;
    if (we_i && waddr_i == REG_STATUS) status_f = wdata_i;
    if (we_i && waddr_i == REG_CAUSE)  cause_f[9:8] = wdata_i[9:8];
    if (we_i && waddr_i == REG_EPC)    epc_f = wdata_i;
    int_pending = status_f[ST_IE] & ~status_f[ST_EXL] &
                  (|(cause_f[15:8] & status_f[15:8]));
  end

  // Priority encode interrupts and MEM-stage exception flags.
  always_comb begin
    exc_type = EXC_NONE;
    if (mem_valid_i && mem_pc_i != 32'h0) begin
      if (int_pending)            exc_type = EXC_INT;
      else if (mem_excflags_i[0]) exc_type = EXC_ADEL;
      else if (mem_excflags_i[1]) exc_type = EXC_RI;
      else if (mem_excflags_i[2]) exc_type = EXC_OV;
      else if (mem_excflags_i[3]) exc_type = EXC_TR;
      else if (mem_excflags_i[4]) exc_type = EXC_SYS;
      else if (mem_excflags_i[5]) exc_type = EXC_BP;
      else if (mem_excflags_i[6]) exc_type = mem_is_store_i ? EXC_ADES : EXC_ADEL;
      else if (mem_excflags_i[7]) exc_type = EXC_ERET;
    end
  end

  // Next CP0 state: exception entry / ERET take precedence over MTC0.
  always_comb begin
    badvaddr_d  = badvaddr_q;
    compare_d   = compare_q;
    status_d    = status_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    timer_int_d = timer_int_q;

    take_exc = (exc_type != EXC_NONE) && (exc_type != EXC_ERET);
    is_eret  = (exc_type == EXC_ERET);
    // The MTC0 issuer is killed by an exception or ERET in the same cycle.
    wr_ok    = we_i & ~(take_exc | is_eret);

    count_d = count_q + 32'd1;
    if (wr_ok && waddr_i == REG_COUNT) count_d = wdata_i;

    if (compare_q != 32'h0 && count_q == compare_q) timer_int_d = 1'b1;
    if (wr_ok && waddr_i == REG_COMPARE) begin
      compare_d   = wdata_i;
      timer_int_d = 1'b0;
    end

    ip_hw          = int_i | (timer_int_q ? TIMER_MASK : 6'd0);
    cause_d[15:10] = ip_hw;

    if (take_exc) begin
      if (!status_q[ST_EXL]) begin
        epc_d          = mem_in_delayslot_i ? (mem_pc_i - 32'd4) : mem_pc_i;
        cause_d[CA_BD] = mem_in_delayslot_i;
      end
      status_d[ST_EXL] = 1'b1;
      cause_d[6:2]     = (exc_type == EXC_INT) ? 5'd0 : exc_type[4:0];
      if (exc_type == EXC_ADEL || exc_type == EXC_ADES) badvaddr_d = mem_bad_addr_i;
    end else if (is_eret) begin
      status_d[ST_EXL] = 1'b0;
    end else if (wr_ok) begin
      if (waddr_i == REG_STATUS) status_d    = wdata_i;
      if (waddr_i == REG_CAUSE)  cause_d[9:8] = wdata_i[9:8];
      if (waddr_i == REG_EPC)    epc_d       = wdata_i;
    end
  end

  // CP0 state registers; reset overrides every update.
  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q  <= 32'h0;
      count_q     <= 32'h0;
      compare_q   <= 32'h0;
      status_q    <= RESET_STATUS;
      cause_q     <= 32'h0;
      epc_q       <= 32'h0;
      timer_int_q <= 1'b0;
    end else begin
      badvaddr_q  <= badvaddr_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      timer_int_q <= timer_int_d;
    end
  end

  // MFC0 read port with forwarding of an MTC0 to the same register.
  always_comb begin
    rdata_o = 32'h0;
    unique case (raddr_i)
      REG_BADVADDR: rdata_o = badvaddr_q;
      REG_COUNT:    rdata_o = (we_i && waddr_i == REG_COUNT) ? wdata_i : count_q;
      REG_COMPARE:  rdata_o = (we_i && waddr_i == REG_COMPARE) ? wdata_i : compare_q;
      REG_STATUS:   rdata_o = status_f;
      REG_CAUSE:    rdata_o = cause_f;
      REG_EPC:      rdata_o = epc_f;
      default:      rdata_o = 32'h0;
    endcase
  end

  assign exception_type_o = exc_type;
  assign cp0_epc_o        = epc_f;
  assign timer_int_o      = timer_int_q;
  assign status_o         = status_q;
  assign cause_o          = cause_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Bench for cp0_exception_unit: table of priority vectors, directed
// multi-cycle sequences, then randomized traffic against a register-file model.
`timescale 1ns/1ps
module tb_cp0_exception_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic        rst;
  logic        mem_valid_i;
  logic [7:0]  mem_excflags_i;
  logic        mem_is_store_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [31:0] mem_bad_addr_i;
  logic [5:0]  int_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [31:0] exception_type_o;
  logic [31:0] cp0_epc_o;
  logic        timer_int_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;

  cp0_exception_unit dut (
    .clk                (clk),
    .rst                (rst),
    .mem_valid_i        (mem_valid_i),
    .mem_excflags_i     (mem_excflags_i),
    .mem_is_store_i     (mem_is_store_i),
    .mem_pc_i           (mem_pc_i),
    .mem_in_delayslot_i (mem_in_delayslot_i),
    .mem_bad_addr_i     (mem_bad_addr_i),
    .int_i              (int_i),
    .we_i               (we_i),
    .waddr_i            (waddr_i),
    .wdata_i            (wdata_i),
    .raddr_i            (raddr_i),
    .rdata_o            (rdata_o),
    .exception_type_o   (exception_type_o),
    .cp0_epc_o          (cp0_epc_o),
    .timer_int_o        (timer_int_o),
    .status_o           (status_o),
    .cause_o            (cause_o)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // CP0 kept as a register file indexed by register number.
  logic [31:0] m_reg [32];
  logic        m_tim;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_reg[12] = 32'h0040_0000;
    m_tim     = 1'b0;
  endfunction

  // Value of register n as seen this cycle, including an MTC0 in flight.
  function automatic logic [31:0] m_view(input int n);
    logic [31:0] v;
    v = m_reg[n];
    if (we_i && int'(waddr_i) == n) begin
      if (n == 13) v[9:8] = wdata_i[9:8];
      else if (n == 9 || n == 11 || n == 12 || n == 14) v = wdata_i;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_code();
    logic [31:0] codes [8];
    logic [31:0] sf, cf;
    codes = '{32'h4, 32'ha, 32'hc, 32'hd, 32'h8, 32'h9, 32'h4, 32'he};
    if (!mem_valid_i || mem_pc_i == 32'h0) return 32'h0;
    sf = m_view(12);
    cf = m_view(13);
    if (sf[0] && !sf[1] && ((cf[15:8] & sf[15:8]) != 8'h0)) return 32'h1;
    for (int i = 0; i < 8; i++)
      if (mem_excflags_i[i]) return (i == 6 && mem_is_store_i) ? 32'h5 : codes[i];
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_read();
    int n;
    n = int'(raddr_i);
    if (n == 8 || n == 9 || n == 11 || n == 12 || n == 13 || n == 14) return m_view(n);
    return 32'h0;
  endfunction

  function automatic void m_next();
    logic [31:0] code;
    logic        wr;
    logic [31:0] nxt [32];
    logic        ntim;
    code = m_code();
    wr   = we_i && (code == 32'h0);
    for (int i = 0; i < 32; i++) nxt[i] = m_reg[i];
    ntim = m_tim;
    nxt[9] = m_reg[9] + 32'd1;
    if (m_reg[11] != 0 && m_reg[9] == m_reg[11]) ntim = 1'b1;
    nxt[13][15:10] = {m_tim | int_i[5], int_i[4:0]};
    if (code == 32'he) begin
      nxt[12][1] = 1'b0;
    end else if (code != 32'h0) begin
      if (!m_reg[12][1]) begin
        nxt[14]     = mem_in_delayslot_i ? mem_pc_i - 32'd4 : mem_pc_i;
        nxt[13][31] = mem_in_delayslot_i;
      end
      nxt[12][1]    = 1'b1;
      nxt[13][6:2]  = (code == 32'h1) ? 5'd0 : code[4:0];
      if (code == 32'h4 || code == 32'h5) nxt[8] = mem_bad_addr_i;
    end else if (wr) begin
      case (waddr_i)
        5'd9:  nxt[9] = wdata_i;
        5'd11: begin nxt[11] = wdata_i; ntim = 1'b0; end
        5'd12: nxt[12] = wdata_i;
        5'd13: nxt[13][9:8] = wdata_i[9:8];
        5'd14: nxt[14] = wdata_i;
        default: ;
      endcase
    end
    for (int i = 0; i < 32; i++) m_reg[i] = nxt[i];
    m_tim = ntim;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    mem_valid_i = 1'b0; mem_excflags_i = 8'h0; mem_is_store_i = 1'b0;
    mem_pc_i = 32'h0; mem_in_delayslot_i = 1'b0; mem_bad_addr_i = 32'h0;
    int_i = 6'h0; we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'h0; raddr_i = 5'd0;
  endtask

  // Called just after a falling edge with inputs set: check, clock, advance model.
  task automatic step();
    #1;
    chk("exc_type", exception_type_o, m_code());
    chk("epc_fwd", cp0_epc_o, m_view(14));
    chk("rdata", rdata_o, m_read());
    chk("timer", {31'd0, timer_int_o}, {31'd0, m_tim});
    chk("status", status_o, m_reg[12]);
    chk("cause", cause_o, m_reg[13]);
    @(posedge clk);
    if (rst) m_reset(); else m_next();
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); we_i = 1'b1; waddr_i = a; wdata_i = d;
    step();
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [7:0]  flags;
    logic        store;
    logic [5:0]  irq;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [16];

  int regs_pick [7];
  logic found;

  // ---------------- stimulus ----------------
  initial begin
    tbl[0]  = '{1'b1, 32'h100, 8'h01, 1'b0, 6'h0, 32'h4};
    tbl[1]  = '{1'b1, 32'h100, 8'h02, 1'b0, 6'h0, 32'ha};
    tbl[2]  = '{1'b1, 32'h100, 8'h04, 1'b0, 6'h0, 32'hc};
    tbl[3]  = '{1'b1, 32'h100, 8'h08, 1'b0, 6'h0, 32'hd};
    tbl[4]  = '{1'b1, 32'h100, 8'h10, 1'b0, 6'h0, 32'h8};
    tbl[5]  = '{1'b1, 32'h100, 8'h20, 1'b0, 6'h0, 32'h9};
    tbl[6]  = '{1'b1, 32'h100, 8'h40, 1'b0, 6'h0, 32'h4};
    tbl[7]  = '{1'b1, 32'h100, 8'h40, 1'b1, 6'h0, 32'h5};
    tbl[8]  = '{1'b1, 32'h100, 8'h80, 1'b0, 6'h0, 32'he};
    tbl[9]  = '{1'b1, 32'h100, 8'hff, 1'b1, 6'h0, 32'h4};
    tbl[10] = '{1'b1, 32'h100, 8'h7e, 1'b1, 6'h0, 32'ha};
    tbl[11] = '{1'b0, 32'h100, 8'h40, 1'b0, 6'h0, 32'h0};
    tbl[12] = '{1'b1, 32'h0,   8'h10, 1'b0, 6'h0, 32'h0};
    tbl[13] = '{1'b1, 32'h100, 8'h00, 1'b0, 6'h1, 32'h0};
    tbl[14] = '{1'b1, 32'h100, 8'hc0, 1'b1, 6'h0, 32'h5};
    tbl[15] = '{1'b1, 32'h100, 8'h41, 1'b1, 6'h0, 32'h4};
    regs_pick = '{8, 9, 11, 12, 13, 14, 3};

    // reset
    idle();
    rst = 1'b1;
    @(posedge clk); m_reset();
    @(posedge clk); m_reset();
    @(negedge clk);
    rst = 1'b0;

    raddr_i = 5'd12; #1 chk("rst_status", rdata_o, 32'h0040_0000);
    raddr_i = 5'd13; #1 chk("rst_cause", rdata_o, 32'h0);
    raddr_i = 5'd14; #1 chk("rst_epc", rdata_o, 32'h0);
    chk("rst_exc", exception_type_o, 32'h0);
    chk("rst_epc_o", cp0_epc_o, 32'h0);

    // priority table, evaluated combinationally within one low phase
    for (int i = 0; i < 16; i++) begin
      mem_valid_i = tbl[i].valid; mem_pc_i = tbl[i].pc; mem_excflags_i = tbl[i].flags;
      mem_is_store_i = tbl[i].store; int_i = tbl[i].irq;
      #1 chk($sformatf("tbl%0d", i), exception_type_o, tbl[i].exp);
    end
    idle();
    @(negedge clk);
    // keep model aligned with the idle edge that just passed
    m_next();

    // syscall entry
    idle(); mem_valid_i = 1'b1; mem_excflags_i = 8'h10; mem_pc_i = 32'hbfc0_0100;
    #1 chk("sys_code", exception_type_o, 32'h8);
    step();
    idle(); raddr_i = 5'd14;
    #1 chk("sys_epc", rdata_o, 32'hbfc0_0100);
    chk("sys_exl", {31'd0, status_o[1]}, 32'h1);
    chk("sys_exccode", {27'd0, cause_o[6:2]}, 32'h8);
    step();

    // eret clears EXL
    idle(); mem_valid_i = 1'b1; mem_excflags_i = 8'h80; mem_pc_i = 32'h100;
    step();

    // overflow in delay slot
    idle(); mem_valid_i = 1'b1; mem_excflags_i = 8'h04; mem_pc_i = 32'h8000_0014;
    mem_in_delayslot_i = 1'b1;
    #1 chk("ov_code", exception_type_o, 32'hc);
    step();
    idle(); raddr_i = 5'd14;
    #1 chk("ov_epc", rdata_o, 32'h8000_0010);
    chk("ov_bd", {31'd0, cause_o[31]}, 32'h1);
    step();
    // nested exception while EXL=1 keeps EPC
    idle(); mem_valid_i = 1'b1; mem_excflags_i = 8'h10; mem_pc_i = 32'h9000_0000;
    step();
    idle(); raddr_i = 5'd14;
    #1 chk("nest_epc", rdata_o, 32'h8000_0010);
    chk("nest_exccode", {27'd0, cause_o[6:2]}, 32'h8);
    step();

    // EPC forwarding alongside ERET, write discarded
    mtc0(5'd14, 32'haaaa_0000);
    idle(); we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h1234_5678;
    mem_valid_i = 1'b1; mem_excflags_i = 8'h80; mem_pc_i = 32'h200;
    #1 chk("fwd_epc", cp0_epc_o, 32'h1234_5678);
    chk("fwd_code", exception_type_o, 32'he);
    step();
    idle(); raddr_i = 5'd14;
    #1 chk("fwd_epc_kept", rdata_o, 32'haaaa_0000);
    chk("fwd_exl", {31'd0, status_o[1]}, 32'h0);
    step();

    // timer interrupt
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    idle(); raddr_i = 5'd9;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      #1;
      if (timer_int_o) found = 1'b1;
      else step();
    end
    chk("timer_seen", {31'd0, found}, 32'h1);
    chk("timer_count", rdata_o, 32'd6);
    step();
    idle(); mem_valid_i = 1'b1; mem_excflags_i = 8'h02; mem_pc_i = 32'h300;
    #1 chk("timer_irq_code", exception_type_o, 32'h1);
    step();
    mtc0(5'd11, 32'd100);
    idle();
    #1 chk("timer_clear", {31'd0, timer_int_o}, 32'h0);
    step();

    // AdEL fetch beats store AdES, BadVAddr captured
    idle(); mem_valid_i = 1'b1; mem_excflags_i = 8'h41; mem_is_store_i = 1'b1;
    mem_pc_i = 32'h400; mem_bad_addr_i = 32'hdead_beef;
    #1 chk("adel_code", exception_type_o, 32'h4);
    step();
    idle(); raddr_i = 5'd8;
    #1 chk("badvaddr", rdata_o, 32'hdead_beef);
    step();

    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      mem_valid_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) mem_excflags_i[$urandom_range(0, 7)] = 1'b1;
      if ($urandom_range(0, 7) == 0) mem_excflags_i = 8'($urandom);
      mem_is_store_i = 1'($urandom_range(0, 1));
      mem_pc_i = ($urandom_range(0, 15) == 0) ? 32'h0 : {$urandom} & 32'hffff_fffc;
      mem_in_delayslot_i = 1'($urandom_range(0, 1));
      mem_bad_addr_i = $urandom;
      if ($urandom_range(0, 3) == 0) int_i = 6'($urandom);
      we_i = ($urandom_range(0, 2) == 0);
      waddr_i = 5'(regs_pick[$urandom_range(0, 6)]);
      wdata_i = $urandom;
      if (waddr_i == 5'd11 && $urandom_range(0, 1) == 1) wdata_i = m_reg[9] + $urandom_range(1, 6);
      if (waddr_i == 5'd12 && $urandom_range(0, 1) == 1) wdata_i = $urandom & 32'h0000_ff01;
      raddr_i = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) raddr_i = 5'(regs_pick[$urandom_range(0, 6)]);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_exception_unit.md
Name: cp0_exception_unit

Overview:
- Producer side of the pipeline-control exception interface.
- Sits at the MEM/WB boundary and holds the CP0 registers: BadVAddr, Count, Compare, Status, Cause, EPC.
- Merges raw MEM-stage exception flags and pending interrupts into one encoded exception_type_o, updates CP0 state on exception entry and ERET, and supplies cp0_epc_o (with write forwarding) to the controller that generates new_pc/flush.
- MTC0 writes and MFC0 reads also go through this block.

Parameters:
- RESET_STATUS, 32'h0040_0000, Status reset value (BEV=1, IE=0, EXL=0, IM=0).
- TIMER_IP_BIT, 7, Cause.IP bit set by the Count/Compare timer.

Ports:
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high.
- mem_valid_i  in  1  MEM stage holds a real, unflushed instruction.
- mem_excflags_i  in  8  raw flags: [0] fetch AdEL, [1] reserved instr, [2] overflow, [3] trap, [4] syscall, [5] break, [6] data AdEL/AdES, [7] eret.
- mem_is_store_i  in  1  selects AdES (1) or AdEL (0) for flag [6].
- mem_pc_i  in  32  PC of the MEM instruction.
- mem_in_delayslot_i  in  1  MEM instruction is in a delay slot.
- mem_bad_addr_i  in  32  faulting address for flags [0]/[6].
- int_i  in  6  external hardware interrupts, level-sensitive.
- we_i  in  1  MTC0 write enable.
- waddr_i  in  5  MTC0 register number.
- wdata_i  in  32  MTC0 data.
- raddr_i  in  5  MFC0 register number.
- rdata_o  out  32  MFC0 data, combinational.
- exception_type_o  out  32  encoded exception type to the controller.
- cp0_epc_o  out  32  EPC, forwarded.
- timer_int_o  out  1  timer interrupt pending.
- status_o  out  32  current Status.
- cause_o  out  32  current Cause.

Behaviour:
- Register numbers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Reads of any other number return 0.
- Reset (synchronous, rst=1 at a clk edge): Count=0, Compare=0, Status=RESET_STATUS, Cause=0, EPC=0, BadVAddr=0, timer_int_o=0. Outputs are combinational from these values, so after reset exception_type_o=0, cp0_epc_o=0, rdata_o reflects the reset values.
- Rst asserted mid-operation overrides all pending writes and exception updates that cycle.
- Forwarding: define Status_f, Cause_f, EPC_f as wdata_i when we_i=1 and waddr_i matches, else the stored value.
  - Only Cause bits IP[1:0] (9:8) are MTC0-writable; Status_f and EPC_f are fully writable.
  - cp0_epc_o=EPC_f. rdata_o also forwards when raddr_i==waddr_i.
- Interrupt pending: Cause.IP[7:2] = {timer_int_o|int_i[5], int_i[4:0]}, sampled each cycle. int_pending = Status_f.IE & ~Status_f.EXL & |(Cause_f.IP & Status_f.IM).
- exception_type_o is combinational and is 0 when mem_valid_i=0 or mem_pc_i==0. Otherwise priority, highest first:
  - int_pending → 0x1
  - [0] → 0x4
  - [1] → 0xa
  - [2] → 0xc
  - [3] → 0xd
  - [4] → 0x8
  - [5] → 0x9
  - [6] → 0x5 if mem_is_store_i else 0x4
  - [7] → 0xe
  - else 0
- Exception entry at the clk edge when exception_type_o ∉ {0, 0xe}:
  - If Status.EXL=0: EPC ← delayslot ? pc−4 : pc; Cause.BD ← delayslot.
  - Status.EXL ← 1.
  - Cause.ExcCode ← 0 for interrupt, else code[4:0].
  - BadVAddr ← mem_bad_addr_i for codes 0x4/0x5.
- ERET (0xe): Status.EXL ← 0; no other field changes.
- Same cycle as an exception or ERET: the MTC0 write is discarded, because the writer is being killed. Count still increments.
- Count increments by 1 every cycle and wraps 0xFFFF_FFFF→0. An MTC0 to Count loads wdata_i instead of incrementing.
- Timer:
  - timer_int_o sets on the edge where Compare≠0 and Count==Compare.
  - It clears on any MTC0 to Compare and is otherwise sticky.
  - Simultaneous match and Compare write: the clear wins.
- Latency: exception_type_o and cp0_epc_o are same-cycle combinational. All CP0 state updates become visible the following cycle.

Test Plan:
- Reset, then MFC0 reg 12 → 0x0040_0000; reg 13, 14 → 0; exception_type_o=0.
- Syscall: mem_valid_i=1, flags=0x10, pc=0xbfc0_0100, not in delay slot → exception_type_o=0x8 that cycle; next cycle EPC=0xbfc0_0100, Cause.ExcCode=8, Status.EXL=1.
- Delay-slot overflow: flags=0x04, pc=0x8000_0014, delayslot=1 → code 0xc; EPC=0x8000_0010, Cause.BD=1. A second exception while EXL=1 leaves EPC unchanged.
- Forwarding: MTC0 EPC=0x1234_5678 in the same cycle as ERET (flag 0x80, with a prior EPC write already committed) → cp0_epc_o equals the forwarded value, exception_type_o=0xe; next cycle EXL=0 and EPC is unchanged by the discarded write.
- Timer: write Status=0x0000_8001, Compare=5, Count=0 → timer_int_o=1 at count 5. Next valid instruction → code 0x1 with priority over flags=0x02. MTC0 to Compare clears timer_int_o.
- Masked/invalid cases: int_i[0]=1 with IM=0 → code 0. flags=0x40 with mem_valid_i=0 → code 0. flags=0x41, store=1 → 0x4 (fetch AdEL wins); BadVAddr ← mem_bad_addr_i.
